// File: rtl/game_display_if.sv
// Game-state inputs and display drive outputs of the river-crossing scan
// back end, grouped into one bundle. The game side is the master and the
// scan/display block is the slave.
interface game_display_if;
  logic       sw6;
  logic [1:0] cnt_cat;
  logic [1:0] cnt_dog;
  logic [1:0] cnt_mouse;
  logic [3:0] cnt_canoe;
  logic       cat_crossing;
  logic       dog_crossing;
  logic       mouse_crossing;
  logic       canoe_crossing;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] gameState;
  logic [1:0] gameDifficulty;
  logic [7:0] row;
  logic [7:0] col_r;
  logic [7:0] col_g;
  logic [7:0] seg;
  logic [7:0] dig;

  modport master (
    output sw6, cnt_cat, cnt_dog, cnt_mouse, cnt_canoe,
    output cat_crossing, dog_crossing, mouse_crossing, canoe_crossing,
    output ones, tens, gameState, gameDifficulty,
    input  row, col_r, col_g, seg, dig
  );

  modport slave (
    input  sw6, cnt_cat, cnt_dog, cnt_mouse, cnt_canoe,
    input  cat_crossing, dog_crossing, mouse_crossing, canoe_crossing,
    input  ones, tens, gameState, gameDifficulty,
    output row, col_r, col_g, seg, dig
  );
endinterface

// File: rtl/game_display_scan.sv
// Display back end for the river-crossing game: scans an 8x8 red/green dot
// matrix and an 8-digit 7-segment bank from one shared slot index. Game
// inputs are captured once per frame so a frame never shows a mix of old
// and new state.
module game_display_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 250
) (
  input logic           clk_1kHz,
  input logic           rst,
  game_display_if.slave bus
);

  localparam logic [7:0]  SCAN_LAST  = 8'(SCAN_DIV - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

  // BCD digit to {dp,g,f,e,d,c,b,a}; anything above 9 is blank.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 8'h3F;
      4'd1:    bcd_to_seg = 8'h06;
      4'd2:    bcd_to_seg = 8'h5B;
      4'd3:    bcd_to_seg = 8'h4F;
      4'd4:    bcd_to_seg = 8'h66;
      4'd5:    bcd_to_seg = 8'h6D;
      4'd6:    bcd_to_seg = 8'h7D;
      4'd7:    bcd_to_seg = 8'h07;
      4'd8:    bcd_to_seg = 8'h7F;
      4'd9:    bcd_to_seg = 8'h6F;
      default: bcd_to_seg = 8'h00;
    endcase
  endfunction

  // Lane position 0..3 spread over the 8 columns as 0,2,5,7 (2*c + c[1]).
  function automatic logic [2:0] animal_col(input logic [1:0] c);
    animal_col = {c, 1'b0} + {2'b00, c[1]};
  endfunction

  logic [7:0]  scan_cnt;
  logic [2:0]  idx;
  logic [15:0] blink_cnt;
  logic        blink;

  logic [1:0] snap_cat_r, snap_dog_r, snap_mouse_r;
  logic [3:0] snap_canoe_r;
  logic       snap_cat_x_r, snap_dog_x_r, snap_mouse_x_r, snap_canoe_x_r;
  logic [3:0] snap_ones_r, snap_tens_r;
  logic [1:0] snap_state_r, snap_diff_r;

  logic       scan_wrap_s;
  logic       blink_wrap_s;
  logic [7:0] onehot_s;
  logic [7:0] row_s, col_r_s, col_g_s, seg_s, dig_s;

  assign scan_wrap_s  = (scan_cnt == SCAN_LAST);
  assign blink_wrap_s = (blink_cnt == BLINK_LAST);
  assign onehot_s     = 8'h01 << idx;

  // Slot timing and blink phase generation.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      scan_cnt  <= 8'd0;
      idx       <= 3'd0;
      blink_cnt <= 16'd0;
      blink     <= 1'b0;
    end else begin
      if (scan_wrap_s) begin
        scan_cnt <= 8'd0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 8'd1;
      end
      if (blink_wrap_s) begin
        blink_cnt <= 16'd0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Capture all game inputs at the end of slot 7, i.e. on the frame boundary.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      snap_cat_r     <= 2'd0;
      snap_dog_r     <= 2'd0;
      snap_mouse_r   <= 2'd0;
      snap_canoe_r   <= 4'd0;
      snap_cat_x_r   <= 1'b0;
      snap_dog_x_r   <= 1'b0;
      snap_mouse_x_r <= 1'b0;
      snap_canoe_x_r <= 1'b0;
      snap_ones_r    <= 4'd0;
      snap_tens_r    <= 4'd0;
      snap_state_r   <= 2'd0;
      snap_diff_r    <= 2'd0;
    end else if (scan_wrap_s && (idx == 3'd7)) begin
      snap_cat_r     <= bus.cnt_cat;
      snap_dog_r     <= bus.cnt_dog;
      snap_mouse_r   <= bus.cnt_mouse;
      snap_canoe_r   <= bus.cnt_canoe;
      snap_cat_x_r   <= bus.cat_crossing;
      snap_dog_x_r   <= bus.dog_crossing;
      snap_mouse_x_r <= bus.mouse_crossing;
      snap_canoe_x_r <= bus.canoe_crossing;
      snap_ones_r    <= bus.ones;
      snap_tens_r    <= bus.tens;
      snap_state_r   <= bus.gameState;
      snap_diff_r    <= bus.gameDifficulty;
    end else begin
      snap_cat_r <= snap_cat_r;
    end
  end

  // Render the current slot from the snapshot; power-off blanks everything.
  always_comb begin
    row_s   = 8'hFF;
    dig_s   = 8'hFF;
    col_r_s = 8'h00;
    col_g_s = 8'h00;
    seg_s   = 8'h00;
    if (bus.sw6) begin
      row_s = ~onehot_s;
      dig_s = ~onehot_s;
      case (snap_state_r)
        2'd2: begin
          case (idx)
            3'd0: col_g_s = 8'h3C;
            3'd1: col_r_s = (!snap_cat_x_r || blink) ? (8'h01 << animal_col(snap_cat_r)) : 8'h00;
            3'd3: col_r_s = (!snap_dog_x_r || blink) ? (8'h01 << animal_col(snap_dog_r)) : 8'h00;
            3'd5: col_r_s = (!snap_mouse_x_r || blink) ? (8'h01 << animal_col(snap_mouse_r)) : 8'h00;
            3'd7: begin
              col_r_s = (!snap_canoe_x_r || blink) ? (8'h01 << snap_canoe_r[3:1]) : 8'h00;
              col_g_s = col_r_s;
            end
            default: col_r_s = 8'h00;
          endcase
        end
        2'd1:    col_g_s = blink ? 8'hFF : 8'h00;
        2'd0:    col_r_s = onehot_s | (8'h80 >> idx);
        default: col_r_s = 8'h00;
      endcase
      case (idx)
        3'd0: seg_s = bcd_to_seg(snap_ones_r);
        3'd1: seg_s = (snap_tens_r == 4'd0) ? 8'h00 : bcd_to_seg(snap_tens_r);
        3'd6: begin
          case (snap_state_r)
            2'd0:    seg_s = 8'h38;
            2'd1:    seg_s = 8'h73;
            2'd2:    seg_s = 8'h40;
            default: seg_s = 8'h00;
          endcase
        end
        3'd7:    seg_s = bcd_to_seg({2'b00, snap_diff_r} + 4'd1);
        default: seg_s = 8'h00;
      endcase
    end else begin
      row_s = 8'hFF;
      dig_s = 8'hFF;
    end
  end

  // Register every display output.
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      bus.row   <= 8'hFF;
      bus.col_r <= 8'h00;
      bus.col_g <= 8'h00;
      bus.seg   <= 8'h00;
      bus.dig   <= 8'hFF;
    end else begin
      bus.row   <= row_s;
      bus.col_r <= col_r_s;
      bus.col_g <= col_g_s;
      bus.seg   <= seg_s;
      bus.dig   <= dig_s;
    end
  end

endmodule

// File: tb/tb_game_display_scan.sv
// Scoreboard bench for game_display_scan: each clock edge the bench derives
// the expected outputs from the edge count since reset and its own frame
// snapshot, queues them, and compares once the DUT outputs have settled.
module tb_game_display_scan;

  localparam int SD = 4;
  localparam int BD = 20;
  localparam int FR = 8 * SD;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col_r;
    logic [7:0] col_g;
    logic [7:0] seg;
    logic [7:0] dig;
  } exp_t;

  typedef struct packed {
    logic [1:0] cat, dog, mouse;
    logic [3:0] canoe;
    logic       cx, dx, mx, nx;
    logic [3:0] ones, tens;
    logic [1:0] st, diff;
  } snap_t;

  logic clk_1kHz = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  snap_t snap;
  exp_t  sb_q[$];
  logic [7:0] seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  int cmap [0:3] = '{0, 2, 5, 7};

  always #5 clk_1kHz = ~clk_1kHz;

  game_display_if bus();

  game_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk_1kHz (clk_1kHz),
    .rst      (rst),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  function automatic snap_t grab();
    snap_t s;
    s.cat = bus.cnt_cat;   s.dog = bus.cnt_dog;   s.mouse = bus.cnt_mouse;
    s.canoe = bus.cnt_canoe;
    s.cx = bus.cat_crossing;   s.dx = bus.dog_crossing;
    s.mx = bus.mouse_crossing; s.nx = bus.canoe_crossing;
    s.ones = bus.ones; s.tens = bus.tens;
    s.st = bus.gameState; s.diff = bus.gameDifficulty;
    return s;
  endfunction

  function automatic exp_t model(input int kk, input snap_t s, input logic sw);
    exp_t e;
    int   i;
    logic b;
    i = ((kk - 1) / SD) % 8;
    b = (((kk - 1) / BD) % 2) == 1;
    e.row = 8'hFF; e.dig = 8'hFF; e.col_r = 8'h00; e.col_g = 8'h00; e.seg = 8'h00;
    if (sw) begin
      e.row[i] = 1'b0;
      e.dig[i] = 1'b0;
      if (s.st == 2'd2) begin
        if (i == 0) e.col_g = 8'h3C;
        if (i == 1 && (!s.cx || b)) e.col_r[cmap[s.cat]] = 1'b1;
        if (i == 3 && (!s.dx || b)) e.col_r[cmap[s.dog]] = 1'b1;
        if (i == 5 && (!s.mx || b)) e.col_r[cmap[s.mouse]] = 1'b1;
        if (i == 7 && (!s.nx || b)) begin
          e.col_r[s.canoe / 2] = 1'b1;
          e.col_g[s.canoe / 2] = 1'b1;
        end
      end else if (s.st == 2'd1) begin
        if (b) e.col_g = 8'hFF;
      end else if (s.st == 2'd0) begin
        e.col_r[i] = 1'b1;
        e.col_r[7 - i] = 1'b1;
      end
      if (i == 0 && s.ones <= 4'd9) e.seg = seg_tab[s.ones];
      if (i == 1 && s.tens != 4'd0 && s.tens <= 4'd9) e.seg = seg_tab[s.tens];
      if (i == 6) e.seg = (s.st == 2'd0) ? 8'h38 : (s.st == 2'd1) ? 8'h73 :
                          (s.st == 2'd2) ? 8'h40 : 8'h00;
      if (i == 7) e.seg = seg_tab[s.diff + 1];
    end
    return e;
  endfunction

  // One clock: predict at the edge, compare 1 time unit later.
  task automatic tick();
    exp_t e;
    exp_t got;
    @(posedge clk_1kHz);
    if (rst) begin
      k = 0;
      snap = '0;
      e = '{row: 8'hFF, col_r: 8'h00, col_g: 8'h00, seg: 8'h00, dig: 8'hFF};
    end else begin
      k++;
      e = model(k, snap, bus.sw6);
      if (k % FR == 0) snap = grab();
    end
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check("row",   bus.row,   got.row);
    check("col_r", bus.col_r, got.col_r);
    check("col_g", bus.col_g, got.col_g);
    check("seg",   bus.seg,   got.seg);
    check("dig",   bus.dig,   got.dig);
  endtask

  initial begin
    rst = 1'b1;
    bus.sw6 = 1'b1;
    bus.cnt_cat = 2'd0; bus.cnt_dog = 2'd0; bus.cnt_mouse = 2'd0; bus.cnt_canoe = 4'd0;
    bus.cat_crossing = 1'b0; bus.dog_crossing = 1'b0;
    bus.mouse_crossing = 1'b0; bus.canoe_crossing = 1'b0;
    bus.ones = 4'd0; bus.tens = 4'd0; bus.gameState = 2'd0; bus.gameDifficulty = 2'd0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2 * FR) tick();

    // Playing: cat at 2, canoe at 9, dog 1, mouse 3.
    bus.gameState = 2'd2; bus.cnt_cat = 2'd2; bus.cnt_canoe = 4'd9;
    bus.cnt_dog = 2'd1; bus.cnt_mouse = 2'd3;
    repeat (2 * FR) tick();

    // Crossing flags make the pixels blink.
    bus.cat_crossing = 1'b1; bus.cnt_cat = 2'd0; bus.canoe_crossing = 1'b1;
    repeat (4 * FR) tick();

    // Lose screen with digits 13, difficulty 2.
    bus.tens = 4'd1; bus.ones = 4'd3; bus.gameDifficulty = 2'd2; bus.gameState = 2'd0;
    repeat (2 * FR) tick();

    // Win screen.
    bus.gameState = 2'd1;
    repeat (3 * FR) tick();

    // Reserved state.
    bus.gameState = 2'd3;
    repeat (2 * FR) tick();

    // Dog moves mid-frame while playing.
    bus.gameState = 2'd2; bus.cat_crossing = 1'b0; bus.canoe_crossing = 1'b0;
    repeat (FR + 3 * SD) tick();
    bus.cnt_dog = 2'd3;
    repeat (2 * FR) tick();

    // Random input churn, including out-of-range BCD.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.cnt_cat = 2'($urandom_range(0, 3));
        bus.cnt_dog = 2'($urandom_range(0, 3));
        bus.cnt_mouse = 2'($urandom_range(0, 3));
        bus.cnt_canoe = 4'($urandom_range(0, 15));
        bus.cat_crossing = 1'($urandom_range(0, 1));
        bus.dog_crossing = 1'($urandom_range(0, 1));
        bus.mouse_crossing = 1'($urandom_range(0, 1));
        bus.canoe_crossing = 1'($urandom_range(0, 1));
        bus.ones = 4'($urandom_range(0, 15));
        bus.tens = 4'($urandom_range(0, 15));
        bus.gameState = 2'($urandom_range(0, 3));
        bus.gameDifficulty = 2'($urandom_range(0, 3));
      end
      tick();
    end

    // Power off mid-frame, then back on.
    repeat (5) tick();
    bus.sw6 = 1'b0;
    repeat (11) tick();
    bus.sw6 = 1'b1;
    repeat (FR) tick();

    // Reset mid-frame.
    repeat (13) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2 * FR) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_display_scan.md
Name: game_display_scan

Overview:
- Display back end for the river-crossing game logic.
- Consumes the game block's position counters, crossing flags, move count (tens/ones), gameState and gameDifficulty.
- Drives a time-multiplexed 8x8 bicolour dot matrix (red/green) and an 8-digit common-cathode 7-segment bank.
- Inputs are snapshotted once per frame so a frame is never torn mid-update.

Parameters:
- SCAN_DIV, 4, clk_1kHz cycles per row/digit slot (range 2..255).
- BLINK_DIV, 250, clk_1kHz cycles per blink half-period (range 2..65535).

Ports:
- clk_1kHz  in  1  scan clock
- rst  in  1  synchronous reset, active-high
- sw6  in  1  power switch; 0 blanks all outputs
- cnt_cat  in  2  cat lane position, 0 = left bank, 3 = right bank
- cnt_dog  in  2  dog lane position
- cnt_mouse  in  2  mouse lane position
- cnt_canoe  in  4  canoe position, 0..15
- cat_crossing, dog_crossing, mouse_crossing, canoe_crossing  in  1 each  crossing-in-progress flags
- ones  in  4  move count, units digit (BCD)
- tens  in  4  move count, tens digit (BCD)
- gameState  in  2  0 = lose, 1 = win, 2 = playing, 3 = reserved
- gameDifficulty  in  2  difficulty level 0..3
- row  out  8  matrix row select, active-low, one-hot
- col_r  out  8  red column drive, active-high
- col_g  out  8  green column drive, active-high
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high
- dig  out  8  digit select, active-low, one-hot

Behaviour:
- Single clock domain clk_1kHz. All state is reset synchronously by rst.
- Reset values:
  - scan_cnt = 0, idx = 0, blink_cnt = 0, blink = 0, all snapshot registers = 0.
  - row = 8'hFF, col_r = 0, col_g = 0, seg = 0, dig = 8'hFF.
- Scan timing:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, idx (3 bits) increments mod 8.
  - Row index and digit index are the same idx.
- Snapshot: when scan_cnt wraps while idx == 7, all game inputs are latched into snapshot registers. Rendering uses snapshot values only, so a frame lasts 8*SCAN_DIV cycles.
- Blink: blink_cnt counts 0..BLINK_DIV-1. On wrap, blink toggles.
- Output latency: outputs are registered. Outputs for slot idx appear the cycle after idx changes and hold for SCAN_DIV cycles.
- Power: while sw6 = 0, row = FF, col_r = col_g = 0, seg = 0, dig = FF. Counters keep running.
- Animal column mapping: col(c) = 2*c + c[1], giving 0->0, 1->2, 2->5, 3->7.
- Matrix, snapshot gameState = 2:
  - Row 0: col_g bits 2..5 set (river band).
  - Rows 1/3/5: cat/dog/mouse. col_r bit col(cnt) set. If that animal's crossing flag = 1, the pixel is shown only while blink = 1.
  - Row 7: col_r and col_g both set (amber) at bit cnt_canoe[3:1]. If canoe_crossing = 1, the pixel blinks.
  - Rows 2, 4, 6: dark.
- Matrix, gameState = 1: all 64 pixels green while blink = 1, dark while blink = 0.
- Matrix, gameState = 0: red X, i.e. pixels where column = idx or column = 7-idx, steady.
- Matrix, gameState = 3: dark.
- Active row: row = ~(1 << idx) whenever sw6 = 1, regardless of gameState.
- 7-segment, dig = ~(1 << idx):
  - idx 0: ones.
  - idx 1: tens, blank when tens = 0.
  - idx 7: gameDifficulty+1 (shows 1..4).
  - idx 6: state letter. gameState 0 -> 'L' (0x38), 1 -> 'P' (0x73), 2 -> '-' (0x40), 3 -> blank.
  - Other idx: seg = 0.
  - BCD values > 9 render blank (seg = 0).
  - dp is always 0.
- Decode table: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- Reset mid-frame: all counters return to 0 on the next edge. The first snapshot is taken at the end of the first full frame; until then, rendering uses the zeroed snapshot.
- Input changes mid-frame: no effect until the next frame boundary.

Test Plan:
- Reset then run 8*SCAN_DIV cycles -> row steps FE, FD, ..., 7F, each held SCAN_DIV cycles. dig tracks row. No X on any output.
- gameState = 2, cnt_cat = 2, crossings = 0, cnt_canoe = 9 -> while row = FD, col_r = 8'h20. While row = 7F, col_r = col_g = 8'h10. While row = FE, col_g = 8'h3C.
- cat_crossing = 1, cnt_cat = 0 -> row-1 col_r toggles between 01 and 00 every BLINK_DIV cycles.
- tens = 1, ones = 3, gameDifficulty = 2, gameState = 0:
  - Digit slots show seg 4F (idx 0), 06 (idx 1), 38 (idx 6), 4F (idx 7).
  - Matrix shows the red X, e.g. row 0 col_r = 81, row 3 col_r = 18.
- Change cnt_dog while idx = 3 -> row-3 column is unchanged until after the next idx 7->0 wrap.
- sw6 = 0 mid-frame -> next cycle row = FF, dig = FF, col_r = col_g = seg = 0. With sw6 = 1 again, scanning resumes at the current idx.
